// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR filter: one shared MAC walks TAPS taps per accepted sample,
// then rounds, scales and saturates the accumulator into a registered output.
module fir_mac_serial #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0,
  localparam int AW       = $clog2(TAPS),
  localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] in_data_i,
  input  logic                     coef_we_i,
  input  logic [AW-1:0]            coef_addr_i,
  input  logic signed [COEF_W-1:0] coef_data_i,
  output logic                     coef_err_o,
  output logic                     out_valid_o,
  output logic signed [OUT_W-1:0]  out_data_o,
  output logic                     busy_o
);
  localparam int PW = DATA_W + COEF_W;
  localparam int RW = ACC_W + 1;
  localparam int EW = ((RW > OUT_W) ? RW : OUT_W) + 1;
  localparam logic signed [EW-1:0] OMAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] OMIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                        state_q;
  logic [AW-1:0]                 idx_q;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [TAPS-1:0][DATA_W-1:0]   x_q;
  logic [TAPS-1:0][COEF_W-1:0]   h_q;
  logic signed [OUT_W-1:0]       out_data_q, out_d;
  logic                          out_valid_q, coef_err_q;

  logic signed [PW-1:0]          prod;
  logic signed [RW-1:0]          acc_x, rnd;
  logic signed [EW-1:0]          rnd_x;
  logic                          idle, coef_ok, coef_wr;

  assign idle    = (state_q == IDLE);
  assign coef_ok = (int'(coef_addr_i) < TAPS);
  assign coef_wr = coef_we_i && idle && coef_ok;

  assign prod  = $signed(x_q[idx_q]) * $signed(h_q[idx_q]);
  assign acc_d = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};

  // One guard bit so the rounding increment cannot wrap the accumulator.
  assign acc_x = {acc_q[ACC_W-1], acc_q};
  generate
    if (OUT_SHIFT > 0) begin : g_rnd
      localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
      assign rnd = (acc_x + HALF) >>> OUT_SHIFT;
    end else begin : g_pass
      assign rnd = acc_x;
    end
  endgenerate

  assign rnd_x = {{(EW-RW){rnd[RW-1]}}, rnd};
  assign out_d = (rnd_x > OMAX) ? OMAX[OUT_W-1:0] :
                 (rnd_x < OMIN) ? OMIN[OUT_W-1:0] : rnd_x[OUT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        h_q[k] <= (k == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      coef_err_q  <= coef_we_i && !coef_wr;
      // Write lands before the MAC reads, so a same-cycle sample sees it.
      if (coef_wr) h_q[coef_addr_i] <= coef_data_i;
      case (state_q)
        IDLE: if (in_valid_i) begin
          for (int k = TAPS-1; k > 0; k--) x_q[k] <= x_q[k-1];
          x_q[0]  <= in_data_i;
          acc_q   <= '0;
          idx_q   <= '0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + AW'(1);
          if (idx_q == AW'(TAPS-1)) state_q <= OUT;
        end
        OUT: begin
          out_data_q  <= out_d;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = idle;
  assign busy_o      = !idle;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign coef_err_o  = coef_err_q;
endmodule

// File: tb/tb_fir_mac_serial.sv
// Three filter configurations share one stimulus stream; a convolution model over a
// sample history predicts handshake timing, coefficient errors and each output.
module tb_fir_mac_serial;
  localparam int TAPS = 6;
  localparam int AW   = $clog2(TAPS);

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, coef_we = 1'b0;
  logic signed [15:0] in_data = '0, coef_data = '0;
  logic [AW-1:0] coef_addr = '0;
  logic [2:0] rdy, bsy, cerr, ov;
  logic signed [31:0] od0, od2;
  logic signed [15:0] od1;

  fir_mac_serial #(.TAPS(TAPS), .OUT_W(32), .OUT_SHIFT(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(rdy[0]), .in_data_i(in_data),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data), .coef_err_o(cerr[0]),
    .out_valid_o(ov[0]), .out_data_o(od0), .busy_o(bsy[0]));
  fir_mac_serial #(.TAPS(TAPS), .OUT_W(16), .OUT_SHIFT(0)) u_sat (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(rdy[1]), .in_data_i(in_data),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data), .coef_err_o(cerr[1]),
    .out_valid_o(ov[1]), .out_data_o(od1), .busy_o(bsy[1]));
  fir_mac_serial #(.TAPS(TAPS), .OUT_W(32), .OUT_SHIFT(2)) u_shf (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(rdy[2]), .in_data_i(in_data),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data), .coef_err_o(cerr[2]),
    .out_valid_o(ov[2]), .out_data_o(od2), .busy_o(bsy[2]));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint fin(input longint a, input int sh, input int ow);
    longint r, mx, mn;
    r = a;
    if (sh > 0) r = (a + (longint'(1) << (sh - 1))) >>> sh;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -mx - 1;
    if (r > mx) r = mx;
    if (r < mn) r = mn;
    return r;
  endfunction

  // Reference model: sample history, coefficient table, expected-result queue.
  typedef struct { longint y0, y1, y2; int due; } exp_t;
  exp_t   q[$];
  exp_t   e;
  longint xh[TAPS], hh[TAPS], acc;
  int     mcnt = 0;
  bit     err_exp = 0, m_ready, m_ov;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ready", rdy, 3'b111);
      chk("rst_busy", bsy, 3'b000);
      chk("rst_valid", ov, 3'b000);
      chk("rst_err", cerr, 3'b000);
      chk("rst_data0", od0, 0);
      chk("rst_data1", od1, 0);
      chk("rst_data2", od2, 0);
      for (int k = 0; k < TAPS; k++) begin xh[k] = 0; hh[k] = (k == 0) ? 1 : 0; end
      q.delete();
      mcnt = 0;
      err_exp = 0;
    end else begin
      m_ready = (mcnt == 0);
      m_ov = (q.size() > 0) && (q[0].due == cyc);
      chk("in_ready", rdy, {3{m_ready}});
      chk("busy", bsy, {3{!m_ready}});
      chk("coef_err", cerr, {3{err_exp}});
      chk("out_valid", ov, {3{m_ov}});
      if (m_ov) begin
        chk("out_data", od0, q[0].y0);
        chk("out_data_sat", od1, q[0].y1);
        chk("out_data_shift", od2, q[0].y2);
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].due < cyc) begin
        void'(q.pop_front());
      end
      // Predict the effect of the coming edge.
      err_exp = coef_we && !(m_ready && coef_addr < TAPS);
      if (coef_we && m_ready && coef_addr < TAPS) hh[coef_addr] = coef_data;
      if (in_valid && m_ready) begin
        for (int k = TAPS-1; k > 0; k--) xh[k] = xh[k-1];
        xh[0] = in_data;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += xh[k] * hh[k];
        e.y0 = fin(acc, 0, 32);
        e.y1 = fin(acc, 0, 16);
        e.y2 = fin(acc, 2, 32);
        e.due = cyc + TAPS + 2;
        q.push_back(e);
        mcnt = TAPS + 1;
      end else if (mcnt > 0) begin
        mcnt--;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic signed [15:0] d, input bit keep);
    int n = 0;
    bit took = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!took && n < 100) begin
      @(negedge clk);
      took = rdy[0];
      @(posedge clk); #1;
      n++;
    end
    if (!took) chk("send_timeout", 0, 1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wr(input int a, input logic signed [15:0] d);
    coef_we = 1'b1; coef_addr = AW'(a); coef_data = d;
    step(1);
    coef_we = 1'b0;
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    // Identity filter, samples with gaps
    send(5, 0); step(12);
    send(-3, 0); step(3);
    send(7, 0); step(TAPS + 4);
    // Impulse response after loading 1,2,3,4,0,0
    repeat (TAPS) send(0, 0);
    wr(1, 2); wr(2, 3); wr(3, 4);
    send(1, 0);
    repeat (TAPS - 1) send(0, 0);
    // Saturation at both rails
    for (int k = 0; k < TAPS; k++) wr(k, 32767);
    repeat (TAPS) send(32767, 0);
    repeat (TAPS) send(-32768, 0);
    // Rounding of the shifted configuration
    wr(0, 1);
    for (int k = 1; k < TAPS; k++) wr(k, 0);
    send(6, 0); send(-6, 0);
    // Back-to-back offers with in_valid held high
    for (int i = 0; i < 20; i++) send(16'($urandom_range(0, 2000)) - 16'sd1000, 1);
    in_valid = 1'b0;
    // Writes while busy and to an out-of-range tap
    send(100, 0); wr(2, 55);
    step(TAPS + 2);
    wr(TAPS + 1, 9);
    // Write and transfer in the same idle cycle
    coef_we = 1'b1; coef_addr = '0; coef_data = 3;
    send(10, 0);
    coef_we = 1'b0;
    step(TAPS + 2);
    // Reset mid-MAC drops the result and restores identity
    wr(1, 5);
    send(4, 0); step(3);
    reset = 1'b1; step(2); reset = 1'b0;
    send(9, 0); step(TAPS + 4);
    // Random mix
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0, 1: send(16'($urandom), 1'($urandom));
        2: wr($urandom_range(0, (1 << AW) - 1), ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 20)));
        default: step($urandom_range(0, 3));
      endcase
    end
    in_valid = 1'b0;
    step(TAPS + 6);
    chk("pending_results", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
